// File: rtl/cus42_scroll_gen_if.sv
// CUS42 scroll generator bus bundle: CPU register window plus tilemap/PROM video path.
// master = CPU decode and video consumer side, slave = cus42_scroll_gen.
interface cus42_scroll_gen_if #(
  parameter int LAYERS = 2
);
  localparam int CA_W = 2 + $clog2(LAYERS);

  logic                    nLATCH;
  logic [CA_W-1:0]         CA;
  logic [7:0]              CD;
  logic [8*LAYERS-1:0]     RD;
  logic [12*LAYERS-1:0]    RA;
  logic [14*LAYERS-1:0]    GA;
  logic [LAYERS-1:0]       S3H;
  logic [3*LAYERS-1:0]     PRI;

  modport master (
    output nLATCH, CA, CD, RD,
    input  RA, GA, S3H, PRI
  );

  modport slave (
    input  nLATCH, CA, CD, RD,
    output RA, GA, S3H, PRI
  );
endinterface

// File: rtl/cus42_scroll_gen.sv
// CUS42-class scroll/tile address generator for LAYERS tilemap layers.
// CPU scroll writes land in staging registers and are committed at the
// nVSYNC falling edge; per-layer H/V counters reload on nHSYNC falling edges.
// Optional screen flip is built when CUS42_FLIP_EN is defined.
// H_BITS and V_BITS are expected to be at least 9 (RA/GA use SH[8:0], SV[7:0]).
module cus42_scroll_gen #(
  parameter int                LAYERS      = 2,
  parameter int                H_BITS      = 9,
  parameter int                V_BITS      = 9,
  parameter logic [H_BITS-1:0] H_FLIP_BASE = 9'd383
) (
  input  logic               CLK_6M,
  input  logic               rst_n,
  input  logic               FLIP,
  input  logic               nHSYNC,
  input  logic               nVSYNC,
  cus42_scroll_gen_if.slave  bus
);

  localparam int CA_W = 2 + $clog2(LAYERS);

  logic [2:0]      latch_sync;
  logic [1:0]      hs_sync;
  logic [1:0]      vs_sync;
  logic            wr_pulse;
  logic            hs_fall;
  logic            vs_fall;
  logic [CA_W-1:0] ca_layer;
  logic            flip_line;
  logic            flip_load;

  // nLATCH two-flop synchroniser plus one history flop for edge detect;
  // syncs register once for edge detect. Reset high so no edge is seen at release.
  always_ff @(posedge CLK_6M or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync <= '1;
      hs_sync    <= '1;
      vs_sync    <= '1;
    end else begin
      latch_sync <= {latch_sync[1:0], bus.nLATCH};
      hs_sync    <= {hs_sync[0], nHSYNC};
      vs_sync    <= {vs_sync[0], nVSYNC};
    end
  end

  assign wr_pulse = latch_sync[2] & ~latch_sync[1];
  assign hs_fall  = hs_sync[1] & ~hs_sync[0];
  assign vs_fall  = vs_sync[1] & ~vs_sync[0];
  assign ca_layer = bus.CA >> 2;

`ifdef CUS42_FLIP_EN
  // FLIP is captured once per line; the reload itself uses the live pin value
  // so the new line starts in the new direction.
  always_ff @(posedge CLK_6M or negedge rst_n) begin
    if (!rst_n) begin
      flip_line <= 1'b0;
    end else if (hs_fall) begin
      flip_line <= FLIP;
    end
  end
  assign flip_load = FLIP;
`else
  logic unused_flip;
  assign unused_flip = FLIP;
  assign flip_line   = 1'b0;
  assign flip_load   = 1'b0;
`endif

  for (genvar g = 0; g < LAYERS; g++) begin : g_layer
    logic [H_BITS-1:0] hs_stg, hs_stg_d, hs_act, hs_act_d, hcnt, sh;
    logic [V_BITS-1:0] vs_stg, vs_stg_d, vs_act, vs_act_d, vcnt, sv;
    logic [2:0]        pri_stg, pri_stg_d, pri_act, pri_act_d;
    logic [7:0]        tile;
    logic [1:0]        attr;
    logic              wr_sel;

    assign wr_sel = wr_pulse && (ca_layer == CA_W'(g));

    // Staging next-state: apply the CPU write addressed to this layer.
    always_comb begin
      hs_stg_d  = hs_stg;
      vs_stg_d  = vs_stg;
      pri_stg_d = pri_stg;
      if (wr_sel) begin
        case (bus.CA[1:0])
          2'd0: hs_stg_d[7:0] = bus.CD;
          2'd1: begin
            hs_stg_d[8] = bus.CD[0];
            pri_stg_d   = bus.CD[3:1];
          end
          2'd2: vs_stg_d[7:0] = bus.CD;
          default: vs_stg_d[8] = bus.CD[0];
        endcase
      end
    end

    // Commit takes the staging next-state so a write landing on the commit
    // cycle is not lost; the same value feeds a coincident counter reload.
    assign hs_act_d  = vs_fall ? hs_stg_d  : hs_act;
    assign vs_act_d  = vs_fall ? vs_stg_d  : vs_act;
    assign pri_act_d = vs_fall ? pri_stg_d : pri_act;

    // Scroll registers and per-layer H/V counters.
    always_ff @(posedge CLK_6M or negedge rst_n) begin
      if (!rst_n) begin
        hs_stg  <= '0;
        vs_stg  <= '0;
        pri_stg <= '0;
        hs_act  <= '0;
        vs_act  <= '0;
        pri_act <= '0;
        hcnt    <= '0;
        vcnt    <= '0;
      end else begin
        hs_stg  <= hs_stg_d;
        vs_stg  <= vs_stg_d;
        pri_stg <= pri_stg_d;
        hs_act  <= hs_act_d;
        vs_act  <= vs_act_d;
        pri_act <= pri_act_d;
        if (hs_fall) begin
          hcnt <= flip_load ? H_FLIP_BASE - hs_act_d : hs_act_d;
          if (vs_fall) begin
            vcnt <= flip_load ? ~vs_act_d : vs_act_d;
          end else begin
            vcnt <= vcnt + 1'b1;
          end
        end else begin
          hcnt <= flip_line ? hcnt - 1'b1 : hcnt + 1'b1;
        end
      end
    end

    assign sh = hcnt ^ {{(H_BITS-3){1'b0}}, {3{flip_line}}};
    assign sv = vcnt ^ {{(V_BITS-3){1'b0}}, {3{flip_line}}};

    // Tile code at SH phase 01, attribute at phase 11.
    always_ff @(posedge CLK_6M or negedge rst_n) begin
      if (!rst_n) begin
        tile <= '0;
        attr <= '0;
      end else if (sh[1:0] == 2'b01) begin
        tile <= bus.RD[8*g +: 8];
      end else if (sh[1:0] == 2'b11) begin
        attr <= bus.RD[8*g +: 2];
      end
    end

    assign bus.RA[12*g +: 12] = {sv[7:3], sh[8:3], sh[1]};
    assign bus.GA[14*g +: 14] = {attr, tile, sv[2:0], sh[2]};
    assign bus.S3H[g]         = &sh[1:0];
    assign bus.PRI[3*g +: 3]  = pri_act;
  end

endmodule

// File: tb/tb_cus42_scroll_gen.sv
// Directed bench for cus42_scroll_gen (LAYERS=2): reset, CPU write/commit,
// HSYNC reloads, tile/attr fetch, and flip behaviour for either build.
module tb_cus42_scroll_gen;

  logic CLK_6M = 1'b0;
  logic rst_n;
  logic FLIP;
  logic nHSYNC;
  logic nVSYNC;

  int checks = 0;
  int errors = 0;

  cus42_scroll_gen_if #(.LAYERS(2)) bus ();

  cus42_scroll_gen #(
    .LAYERS      (2),
    .H_BITS      (9),
    .V_BITS      (9),
    .H_FLIP_BASE (9'd383)
  ) dut (
    .CLK_6M (CLK_6M),
    .rst_n  (rst_n),
    .FLIP   (FLIP),
    .nHSYNC (nHSYNC),
    .nVSYNC (nVSYNC),
    .bus    (bus)
  );

  always #5 CLK_6M = ~CLK_6M;

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_6M);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] addr, input logic [7:0] data);
    bus.CA     = addr;
    bus.CD     = data;
    bus.nLATCH = 1'b0;
    cyc(3);
    bus.nLATCH = 1'b1;
    cyc(3);
  endtask

  task automatic vsync_alone();
    nVSYNC = 1'b0;
    cyc(3);
    nVSYNC = 1'b1;
    cyc(2);
  endtask

  initial begin
    rst_n      = 1'b0;
    FLIP       = 1'b0;
    nHSYNC     = 1'b1;
    nVSYNC     = 1'b1;
    bus.nLATCH = 1'b1;
    bus.CA     = '0;
    bus.CD     = '0;
    bus.RD     = '0;
    cyc(3);
    check("reset_ra", 32'(bus.RA), 32'h0);
    rst_n = 1'b1;
    cyc(5);

    // Mid-line asynchronous reset
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ra",  32'(bus.RA),  32'h0);
    check("midreset_ga",  32'(bus.GA),  32'h0);
    check("midreset_s3h", 32'(bus.S3H), 32'h0);
    check("midreset_pri", 32'(bus.PRI), 32'h0);
    @(negedge CLK_6M);
    rst_n = 1'b1;

    // Free-running counters from 0
    cyc(1); check("run1_ra", 32'(bus.RA), 32'h000000);
    cyc(1); check("run2_ra", 32'(bus.RA), 32'h001001);
    cyc(1); check("run3_s3h", 32'(bus.S3H), 32'h3);
    cyc(5); check("run8_ra", 32'(bus.RA), 32'h002002);

    // Layer 1 HS=0x134, PRI=3; staged only until VSYNC
    cpu_write(3'd4, 8'h34);
    cpu_write(3'd5, 8'h07);
    check("pri_staged", 32'(bus.PRI), 32'h0);
    vsync_alone();
    nHSYNC = 1'b0; nVSYNC = 1'b0;
    cyc(2);
    check("l1_reload_ra",  32'(bus.RA),  32'h04C000);
    check("l1_reload_ga",  32'(bus.GA),  32'h0004000);
    check("l1_reload_pri", 32'(bus.PRI), 32'h18);
    nHSYNC = 1'b1; nVSYNC = 1'b1;
    cyc(2);

    // Mid-frame write: old HS used until the next commit
    cpu_write(3'd0, 8'h20);
    nHSYNC = 1'b0;
    cyc(2);
    check("midframe_old_ra", 32'(bus.RA), 32'h04C000);
    nHSYNC = 1'b1;
    cyc(2);
    vsync_alone();
    nHSYNC = 1'b0;
    cyc(2);
    check("midframe_new_ra0", 32'(bus.RA[11:0]), 32'h008);
    nHSYNC = 1'b1;
    cyc(2);

    // Write pulse coincident with the VSYNC falling edge
    bus.CA = 3'd0; bus.CD = 8'h10; bus.nLATCH = 1'b0;
    cyc(1);
    nVSYNC = 1'b0;
    cyc(2);
    bus.nLATCH = 1'b1;
    cyc(2);
    nVSYNC = 1'b1;
    cyc(3);
    nHSYNC = 1'b0;
    cyc(2);
    check("coincident_ra0", 32'(bus.RA[11:0]), 32'h004);
    nHSYNC = 1'b1;
    cyc(2);

    // Tile/attr fetch with SV=5, SH from 0x010
    cpu_write(3'd2, 8'h05);
    vsync_alone();
    nHSYNC = 1'b0; nVSYNC = 1'b0;
    cyc(2);
    check("fetch_reload_ra0", 32'(bus.RA[11:0]), 32'h004);
    bus.RD[7:0] = 8'hA5;
    nHSYNC = 1'b1; nVSYNC = 1'b1;
    cyc(2);
    check("fetch_tile_ga0", 32'(bus.GA[13:0]), 32'h0A5A);
    bus.RD[7:0] = 8'h02;
    cyc(1);
    check("fetch_s3h0", 32'(bus.S3H[0]), 32'h1);
    cyc(1);
    check("fetch_attr_ga0", 32'(bus.GA[13:0]), 32'h2A5B);
    bus.RD = '0;

    // Flip with HS=0 on layer 0 (vertical counter becomes 6)
    cpu_write(3'd0, 8'h00);
    vsync_alone();
    FLIP   = 1'b1;
    nHSYNC = 1'b0;
    cyc(2);
`ifdef CUS42_FLIP_EN
    check("flip_reload_ra0", 32'(bus.RA[11:0]), 32'h05E);
    check("flip_reload_ga0", 32'(bus.GA[3:0]),  32'h2);
`else
    check("flip_reload_ra0", 32'(bus.RA[11:0]), 32'h000);
    check("flip_reload_ga0", 32'(bus.GA[3:0]),  32'hC);
`endif
    nHSYNC = 1'b1;
    cyc(2);
`ifdef CUS42_FLIP_EN
    check("flip_step_ra0", 32'(bus.RA[11:0]), 32'h05F);
`else
    check("flip_step_ra0", 32'(bus.RA[11:0]), 32'h001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
